// File: rtl/tpu_pkg.sv
// Shared TPU definitions: BF16/E4M3 field layout, exponent biases and the drain FSM state type.
package tpu_pkg;

  localparam int BF16_W      = 16;
  localparam int BF16_EXP_W  = 8;
  localparam int BF16_MAN_W  = 7;
  localparam int FP8_W       = 8;
  localparam int E4M3_EXP_W  = 4;
  localparam int E4M3_MAN_W  = 3;

  localparam int BF16_BIAS   = 127;
  localparam int E4M3_BIAS   = 7;
  // Rebias offset applied to the BF16 exponent to land in E4M3 range.
  localparam int BIAS_OFFSET = BF16_BIAS - E4M3_BIAS;

  localparam logic [6:0] E4M3_MAX_MAG = 7'h7F;

  typedef enum logic {
    DRAIN_IDLE   = 1'b0,
    DRAIN_STREAM = 1'b1
  } drain_state_e;

endpackage

// File: rtl/bf16_to_fp8.sv
// Combinational BF16 -> FP8 E4M3 requantizer: RNE rounding, flush-to-zero, saturate to +-480.
module bf16_to_fp8
  import tpu_pkg::*;
(
  input  logic [BF16_W-1:0] bf16,
  output logic [FP8_W-1:0]  fp8,
  output logic              sat
);

  logic                  w_s;
  logic [BF16_EXP_W-1:0] w_e;
  logic [BF16_MAN_W-1:0] w_m;
  logic signed [8:0]     w_ef;
  logic signed [8:0]     w_ef_rnd;
  logic                  w_up;
  logic [E4M3_MAN_W:0]   w_mant_sum;

  always_comb begin
    w_s        = bf16[15];
    w_e        = bf16[14:7];
    w_m        = bf16[6:0];
    w_ef       = {1'b0, w_e} - 9'(BIAS_OFFSET);
    // Round to nearest even on the 3 kept mantissa bits; guard m[3], sticky m[2:0].
    w_up       = w_m[3] & ((|w_m[2:0]) | w_m[4]);
    w_mant_sum = {1'b0, w_m[6:4]} + {3'b000, w_up};
    w_ef_rnd   = w_ef + {8'h00, w_mant_sum[3]};

    fp8 = 8'h00;
    sat = 1'b0;
    if (w_e == 8'h00 || w_ef <= 9'sd0) begin
      fp8 = 8'h00;
    end else if (w_ef_rnd > 9'sd15) begin
      fp8 = {w_s, E4M3_MAX_MAG};
      sat = 1'b1;
    end else begin
      fp8 = {w_s, w_ef_rnd[3:0], w_mant_sum[2:0]};
    end
  end

endmodule

// File: rtl/pe_array_drain.sv
// Drain stage: snapshots the NxN BF16 accumulator array on capture and streams it as FP8 rows.
module pe_array_drain
  import tpu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*N*16-1:0]      c_flat,
  input  logic                   capture,
  output logic                   busy,
  output logic                   overrun,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*8-1:0]         out_data,
  output logic [$clog2(N)-1:0]   out_row,
  output logic                   out_last,
  output logic                   out_sat,
  output drain_state_e           o_dbg_state
);

  localparam int RW = $clog2(N);

  // out_valid/busy come from the state register only, so out_ready never feeds back
  // into out_valid; a beat transfers on any cycle with out_valid & out_ready.
  drain_state_e        r_state;
  drain_state_e        w_state_nxt;
  logic [RW-1:0]       r_row;
  logic [N*N*16-1:0]   r_bank;
  logic                r_overrun;

  logic                w_fire;
  logic                w_last_fire;
  logic                w_cap_ok;
  logic                w_reject;
  logic [N*16-1:0]     w_row_bf;
  logic [N-1:0]        w_sat;

  always_comb begin
    busy        = (r_state == DRAIN_STREAM);
    out_valid   = busy;
    out_row     = r_row;
    out_last    = (r_row == RW'(N-1));
    overrun     = r_overrun;
    o_dbg_state = r_state;

    w_fire      = out_valid & out_ready;
    w_last_fire = w_fire & out_last;
    w_cap_ok    = 1'b0;
    w_reject    = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      DRAIN_IDLE: begin
        if (capture) begin
          w_cap_ok    = 1'b1;
          w_state_nxt = DRAIN_STREAM;
        end
      end
      DRAIN_STREAM: begin
        // Only a capture aligned with the final beat can reload the bank without losing data.
        if (capture && w_last_fire) begin
          w_cap_ok = 1'b1;
        end else if (capture) begin
          w_reject = 1'b1;
        end
        if (w_last_fire && !capture) begin
          w_state_nxt = DRAIN_IDLE;
        end
      end
      default: w_state_nxt = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= DRAIN_IDLE;
      r_row     <= '0;
      r_bank    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_overrun <= w_reject;
      if (w_cap_ok) begin
        r_bank <= c_flat;
        r_row  <= '0;
      end else if (w_last_fire) begin
        r_row  <= '0;
      end else if (w_fire) begin
        r_row  <= r_row + 1'b1;
      end
    end
  end

  always_comb begin
    w_row_bf = '0;
    for (int r = 0; r < N; r++) begin
      if (r_row == RW'(r)) w_row_bf = r_bank[r*N*16 +: N*16];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_cvt
    bf16_to_fp8 u_cvt (
      .bf16 (w_row_bf[j*16 +: 16]),
      .fp8  (out_data[j*8 +: 8]),
      .sat  (w_sat[j])
    );
  end

  assign out_sat = |w_sat;

endmodule

// File: tb/tb_pe_array_drain.sv
// Directed bench for pe_array_drain (N=4): conversion values, backpressure, back-to-back, overrun, reset.
module tb_pe_array_drain;
  import tpu_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*N*16-1:0] c_flat;
  logic              capture;
  logic              busy;
  logic              overrun;
  logic              out_valid;
  logic              out_ready;
  logic [N*8-1:0]    out_data;
  logic [1:0]        out_row;
  logic              out_last;
  logic              out_sat;
  drain_state_e      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] tab_in  [2][16];
  logic [7:0]  tab_exp [2][16];
  logic        tab_sat [2][4];
  logic [32:0] exp_q[$];

  pe_array_drain #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .c_flat      (c_flat),
    .capture     (capture),
    .busy        (busy),
    .overrun     (overrun),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_last    (out_last),
    .out_sat     (out_sat),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic load_snapshot(input int s);
    for (int i = 0; i < 16; i++) c_flat[i*16 +: 16] = tab_in[s][i];
  endtask

  task automatic expect_snapshot(input int s);
    logic [31:0] d;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) d[j*8 +: 8] = tab_exp[s][r*N+j];
      exp_q.push_back({tab_sat[s][r], d});
    end
  endtask

  task automatic check_beat(input int r, input bit pop);
    logic [32:0] e;
    check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = pop ? exp_q.pop_front() : exp_q[0];
      check($sformatf("data_r%0d", r), out_data, e[31:0]);
      check($sformatf("sat_r%0d", r), 32'(out_sat), 32'(e[32]));
    end
    check($sformatf("row_r%0d", r), 32'(out_row), 32'(r));
    check($sformatf("last_r%0d", r), 32'(out_last), 32'(r == N-1));
    check($sformatf("valid_r%0d", r), 32'(out_valid), 32'd1);
    check($sformatf("busy_r%0d", r), 32'(busy), 32'd1);
  endtask

  initial begin
    // Snapshot A: conversion corner values, expected codes computed by hand.
    tab_in[0]  = '{16'h3F80, 16'h4000, 16'h3F88, 16'h3F98,
                   16'h3FF8, 16'h447A, 16'h3B80, 16'h0000,
                   16'h8000, 16'hC47A, 16'h3F80, 16'h4000,
                   16'h4000, 16'h3F80, 16'h4000, 16'h3F80};
    tab_exp[0] = '{8'h38, 8'h40, 8'h38, 8'h3A,
                   8'h40, 8'h7F, 8'h00, 8'h00,
                   8'h00, 8'hFF, 8'h38, 8'h40,
                   8'h40, 8'h38, 8'h40, 8'h38};
    tab_sat[0] = '{1'b0, 1'b1, 1'b1, 1'b0};
    // Snapshot B: row r = {2.0*2^r, -1.0, 1.25, tiny}.
    for (int r = 0; r < N; r++) begin
      tab_in[1][r*N+0]  = 16'h4000 + 16'(r * 128);
      tab_in[1][r*N+1]  = 16'hBF80;
      tab_in[1][r*N+2]  = 16'h3FA0;
      tab_in[1][r*N+3]  = 16'h0080;
      tab_exp[1][r*N+0] = 8'h40 + 8'(r * 8);
      tab_exp[1][r*N+1] = 8'hB8;
      tab_exp[1][r*N+2] = 8'h3A;
      tab_exp[1][r*N+3] = 8'h00;
      tab_sat[1][r]     = 1'b0;
    end

    rst = 1'b1; capture = 1'b0; out_ready = 1'b0; c_flat = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_row", 32'(out_row), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_sat", 32'(out_sat), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(DRAIN_IDLE));

    // Backpressure: hold out_ready low for 5 cycles after capture.
    load_snapshot(0); expect_snapshot(0);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_beat(0, 0);
      tick();
    end
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      check_beat(r, 1);
      tick();
    end
    check("bp_busy_release", 32'(busy), 32'd0);
    check("bp_valid_release", 32'(out_valid), 32'd0);

    // Back-to-back: capture B on the final handshake of A.
    load_snapshot(0); expect_snapshot(0);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    for (int r = 0; r < N; r++) begin
      check_beat(r, 1);
      if (r == N-1) begin
        load_snapshot(1); expect_snapshot(1);
        capture = 1'b1;
      end
      tick();
    end
    capture = 1'b0;
    check("b2b_overrun", 32'(overrun), 32'd0);
    for (int r = 0; r < N; r++) begin
      check_beat(r, 1);
      tick();
    end
    check("b2b_busy_release", 32'(busy), 32'd0);

    // Overrun: capture during row 1 is rejected, stream of A is unchanged.
    load_snapshot(0); expect_snapshot(0);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    check_beat(0, 1);
    tick();
    check_beat(1, 1);
    load_snapshot(1);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    check("ovr_pulse", 32'(overrun), 32'd1);
    check_beat(2, 1);
    tick();
    check("ovr_clear", 32'(overrun), 32'd0);
    check_beat(3, 1);
    tick();
    check("ovr_busy_release", 32'(busy), 32'd0);
    check("ovr_no_retrigger", 32'(overrun), 32'd0);

    // Reset mid-stream with a simultaneous capture.
    load_snapshot(0); expect_snapshot(0);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    check_beat(0, 1); tick();
    check_beat(1, 1); tick();
    check_beat(2, 1);
    rst = 1'b1; capture = 1'b1;
    tick();
    rst = 1'b0; capture = 1'b0;
    exp_q.delete();
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_overrun", 32'(overrun), 32'd0);
    check("mrst_row", 32'(out_row), 32'd0);
    check("mrst_data", out_data, 32'd0);
    check("mrst_sat", 32'(out_sat), 32'd0);
    tick();
    check("mrst_stay_idle", 32'(busy), 32'd0);
    check("mrst_overrun2", 32'(overrun), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
